// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generator for the pipelined CPU fetch stage.
//               It holds the fetch address and advances it by INC each cycle.
//               Redirect sources, highest priority first: exception entry,
//               exception return, jump, branch, then a buffered redirect.
//               A jump or branch that arrives during a stall is buffered.
//               The buffered redirect is applied on the first unstalled cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising-edge active
//   reset        in   synchronous, active-high reset
//   stall        in   hold pc (hazard unit)
//   br_taken     in   branch redirect request
//   br_target    in   branch target address      [WIDTH]
//   jump         in   jump / jr redirect request
//   jump_target  in   jump target address        [WIDTH]
//   exc_req      in   exception / interrupt entry
//   eret         in   return from exception
//   epc          in   exception return address   [WIDTH]
//   pc           out  current fetch address, registered [WIDTH]
//   pc_seq       out  pc + INC, combinational, wraps modulo 2^WIDTH
//   misaligned   out  pc[1:0] != 0, combinational
//   redir_pend   out  a buffered redirect is waiting, registered
//   redirected   out  pc was loaded from a non-sequential source on the
//                     last edge, registered
// ============================================================================
module pc_gen #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0]   EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter int                 INC        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             misaligned,
    output logic             redir_pend,
    output logic             redirected
);

    localparam logic [WIDTH-1:0] C_INC = WIDTH'(INC);

    logic [WIDTH-1:0] pc_q,   pc_d;
    logic [WIDTH-1:0] tgt_q,  tgt_d;
    logic             pend_q, pend_d;
    logic             redir_q, redir_d;

    // The sum is truncated to WIDTH bits, so it wraps to 0 with no flag.
    assign pc_seq     = pc_q + C_INC;
    assign misaligned = |pc_q[1:0];
    assign pc         = pc_q;
    assign redir_pend = pend_q;
    assign redirected = redir_q;

    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;
        redir_d = 1'b0;

        if (exc_req) begin
            // Exception entry and return are applied even during a stall.
            // They also discard any buffered redirect.
            pc_d    = EXC_VECTOR;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else if (eret) begin
            pc_d    = epc;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else if (stall) begin
            // Hold pc. Buffer the newest redirect, overwriting any older one.
            // Jump wins over branch here, as it does on the direct path.
            if (jump || br_taken) begin
                tgt_d  = jump ? jump_target : br_target;
                pend_d = 1'b1;
            end
        end else if (jump) begin
            // A live redirect is younger than the buffered one, so it wins.
            pc_d    = jump_target;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else if (br_taken) begin
            pc_d    = br_target;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else if (pend_q) begin
            pc_d    = tgt_q;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else begin
            pc_d    = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            redir_q <= redir_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed self-checking bench for pc_gen. One instance uses the
//               default 32-bit configuration. A second instance is 8 bits wide
//               and checks wrap-around of the sequential increment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    wire  [31:0] pc;
    wire  [31:0] pc_seq;
    wire         misaligned;
    wire         redir_pend;
    wire         redirected;

    logic        reset8;
    wire  [7:0]  pc8;
    wire  [7:0]  pc_seq8;
    wire         misaligned8;
    wire         redir_pend8;
    wire         redirected8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .pc          (pc),
        .pc_seq      (pc_seq),
        .misaligned  (misaligned),
        .redir_pend  (redir_pend),
        .redirected  (redirected)
    );

    pc_gen #(
        .WIDTH      (8),
        .RESET_PC   (8'hFC),
        .EXC_VECTOR (8'h80),
        .INC        (4)
    ) dut8 (
        .clk         (clk),
        .reset       (reset8),
        .stall       (1'b0),
        .br_taken    (1'b0),
        .br_target   (8'h00),
        .jump        (1'b0),
        .jump_target (8'h00),
        .exc_req     (1'b0),
        .eret        (1'b0),
        .epc         (8'h00),
        .pc          (pc8),
        .pc_seq      (pc_seq8),
        .misaligned  (misaligned8),
        .redir_pend  (redir_pend8),
        .redirected  (redirected8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
    endtask

    initial begin
        idle();
        br_target = '0; jump_target = '0; epc = '0;
        reset = 1; reset8 = 1;
        step();
        check("rst_pc",      pc, 32'h3000);
        check("rst_pend",    {31'd0, redir_pend}, 32'd0);
        check("rst_redir",   {31'd0, redirected}, 32'd0);
        check("rst_pc8",     {24'd0, pc8}, 32'hFC);
        check("rst_seq8",    {24'd0, pc_seq8}, 32'h00);
        check("rst_pend8",   {30'd0, redir_pend8, redirected8}, 32'd0);
        reset = 0; reset8 = 0;
        step();
        check("wrap_pc8",    {24'd0, pc8}, 32'h00);
        check("wrap_mis8",   {31'd0, misaligned8}, 32'd0);
        check("seq1",        pc, 32'h3004);
        check("seq1_redir",  {31'd0, redirected}, 32'd0);
        step();
        check("seq2",        pc, 32'h3008);
        check("seq2_next",   pc_seq, 32'h300C);

        // Branch redirect
        br_taken = 1; br_target = 32'h3100;
        step();
        check("br_pc",       pc, 32'h3100);
        check("br_redir",    {31'd0, redirected}, 32'd1);
        idle();
        step();
        check("br_after",    pc, 32'h3104);
        check("br_pulse",    {31'd0, redirected}, 32'd0);

        // Jump buffered during a 3-cycle stall
        stall = 1; jump = 1; jump_target = 32'h3200;
        step();
        check("stj_hold",    pc, 32'h3104);
        check("stj_pend",    {31'd0, redir_pend}, 32'd1);
        check("stj_redir",   {31'd0, redirected}, 32'd0);
        jump = 0;
        step();
        step();
        check("stj_hold3",   pc, 32'h3104);
        stall = 0;
        step();
        check("stj_apply",   pc, 32'h3200);
        check("stj_clr",     {31'd0, redir_pend}, 32'd0);
        check("stj_redir1",  {31'd0, redirected}, 32'd1);
        step();
        check("stj_seq",     pc, 32'h3204);

        // A newer branch overwrites the buffered jump
        stall = 1; jump = 1; jump_target = 32'h3200;
        step();
        jump = 0; br_taken = 1; br_target = 32'h3300;
        step();
        br_taken = 0;
        step();
        check("ovw_hold",    pc, 32'h3204);
        stall = 0;
        step();
        check("ovw_apply",   pc, 32'h3300);
        step();
        check("ovw_seq",     pc, 32'h3304);

        // Exception during a stall with a redirect pending, then eret
        stall = 1; jump = 1; jump_target = 32'h3200;
        step();
        check("exc_prepend", {31'd0, redir_pend}, 32'd1);
        jump = 0; exc_req = 1;
        step();
        check("exc_pc",      pc, 32'h4180);
        check("exc_pend",    {31'd0, redir_pend}, 32'd0);
        check("exc_redir",   {31'd0, redirected}, 32'd1);
        exc_req = 0; eret = 1; epc = 32'h3010;
        step();
        check("eret_pc",     pc, 32'h3010);
        idle();
        step();
        check("eret_seq",    pc, 32'h3014);

        // Jump beats branch on the direct path and in the buffer
        jump = 1; jump_target = 32'h3400; br_taken = 1; br_target = 32'h3500;
        step();
        check("jb_direct",   pc, 32'h3400);
        stall = 1; jump_target = 32'h3600; br_target = 32'h3700;
        step();
        idle();
        step();
        check("jb_buffer",   pc, 32'h3600);

        // A live branch beats a buffered jump
        stall = 1; jump = 1; jump_target = 32'h3800;
        step();
        idle(); br_taken = 1; br_target = 32'h3900;
        step();
        check("live_pc",     pc, 32'h3900);
        check("live_pend",   {31'd0, redir_pend}, 32'd0);
        idle();
        step();
        check("live_seq",    pc, 32'h3904);

        // Reset discards a pending redirect
        stall = 1; jump = 1; jump_target = 32'h3A00;
        step();
        idle(); reset = 1;
        step();
        check("mrst_pc",     pc, 32'h3000);
        check("mrst_pend",   {31'd0, redir_pend}, 32'd0);
        reset = 0;
        step();
        check("mrst_seq",    pc, 32'h3004);
        check("mrst_redir",  {31'd0, redirected}, 32'd0);

        // Misaligned target is loaded unmodified
        check("mis_before",  {31'd0, misaligned}, 32'd0);
        jump = 1; jump_target = 32'h3002;
        step();
        check("mis_pc",      pc, 32'h3002);
        check("mis_flag",    {31'd0, misaligned}, 32'd1);
        idle();
        step();
        check("mis_seq",     pc, 32'h3006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
